// File: rtl/strength_bus_arbiter.sv
// -----------------------------------------------------------------------------
// strength_bus_arbiter
//
// Clocked owner of a shared multi-driver net. Each requester presents a data
// value and a 3-bit Verilog drive-strength code. The strongest eligible
// requester gets the net. The block then publishes the owner's value and
// strength on a registered bus. Strength codes:
//   7 supply, 6 strong, 5 pull, 4 large, 3 weak, 2 medium, 1 small, 0 highz.
//
// Arbitration rules:
//   - A highz request is never eligible.
//   - Ties at the maximum strength are broken round-robin, starting from
//     rr_ptr.
//   - A strictly stronger driver preempts the current owner. The bus then
//     spends one dead HANDOVER cycle before the new owner is granted.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        request per requester                      [N_REQ]
//   req_str    strength per requester, slice i = [3i+2:3i] [3*N_REQ]
//   req_data   data per requester, slice i = [DW*i+DW-1:DW*i]
//   grant      one-hot owner, or all zero                 [N_REQ]
//   bus_data   resolved value (owner's data)              [DW]
//   bus_str    owner's current strength                   [3]
//   bus_valid  high whenever grant is nonzero
//   preempt    one-cycle pulse when the owner is displaced by a stronger driver
//   conflict   one-cycle pulse when a grant comes from a tie with differing data
// -----------------------------------------------------------------------------
module strength_bus_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [3*N_REQ-1:0]    req_str,
  input  logic [DW*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      grant,
  output logic [DW-1:0]         bus_data,
  output logic [2:0]            bus_str,
  output logic                  bus_valid,
  output logic                  preempt,
  output logic                  conflict
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    HANDOVER
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] cand;

  // Unpacked views of the flat request buses.
  logic [2:0]       str_of  [N_REQ];
  logic [DW-1:0]    data_of [N_REQ];
  logic [N_REQ-1:0] eligible;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign str_of[g]   = req_str[3*g +: 3];
    assign data_of[g]  = req_data[DW*g +: DW];
    assign eligible[g] = req[g] && (req_str[3*g +: 3] != 3'd0);
  end

  // (base + k) mod N_REQ. This works for non-power-of-two requester counts.
  function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Winner selection. The scan starts at rr_ptr and only replaces the best
  // candidate on a strictly greater strength. The first tied index in
  // round-robin order therefore wins. A second pass flags a conflict when
  // another driver at the winning strength disagrees on data.
  logic [IW-1:0] win_idx;
  logic [2:0]    win_str;
  logic          tie_conflict;
  logic          any_elig;

  always_comb begin
    logic [IW-1:0] idx;
    win_idx      = '0;
    win_str      = 3'd0;
    tie_conflict = 1'b0;
    idx          = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = add_mod(rr_ptr, k);
      if (eligible[idx] && (str_of[idx] > win_str)) begin
        win_str = str_of[idx];
        win_idx = idx;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (eligible[i] && (str_of[i] == win_str) && (data_of[i] != data_of[win_idx]))
        tie_conflict = 1'b1;
    end
  end

  assign any_elig = |eligible;

  // Owner status while holding the bus. Preemption compares against the
  // owner's present request strength, and only a strictly stronger driver
  // qualifies.
  logic       owner_elig;
  logic [2:0] owner_str;
  logic       stronger;

  assign owner_elig = eligible[owner];
  assign owner_str  = str_of[owner];
  assign stronger   = any_elig && (win_str > owner_str);

  // New grant decision for IDLE and HANDOVER. In HANDOVER the preempting
  // candidate wins outright if it is still eligible, and no conflict is
  // reported on that path. Otherwise the cycle falls back to ordinary IDLE
  // arbitration.
  logic          do_grant;
  logic [IW-1:0] grant_idx;
  logic          grant_conflict;

  always_comb begin
    do_grant       = 1'b0;
    grant_idx      = win_idx;
    grant_conflict = 1'b0;
    if (state == IDLE) begin
      if (any_elig) begin
        do_grant       = 1'b1;
        grant_conflict = tie_conflict;
      end
    end else if (state == HANDOVER) begin
      if (eligible[cand]) begin
        do_grant  = 1'b1;
        grant_idx = cand;
      end else if (any_elig) begin
        do_grant       = 1'b1;
        grant_conflict = tie_conflict;
      end
    end
  end

  // Main state machine; all outputs are registered here. preempt and conflict
  // default low, so each event yields exactly one pulse. Release is tested
  // before preemption, so an owner that drops out never reports a preempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      bus_data  <= '0;
      bus_str   <= 3'd0;
      bus_valid <= 1'b0;
      preempt   <= 1'b0;
      conflict  <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
      cand      <= '0;
    end else begin
      preempt  <= 1'b0;
      conflict <= 1'b0;
      if (do_grant) begin
        grant     <= onehot(grant_idx);
        bus_valid <= 1'b1;
        bus_data  <= data_of[grant_idx];
        bus_str   <= str_of[grant_idx];
        owner     <= grant_idx;
        conflict  <= grant_conflict;
        state     <= OWNED;
      end else begin
        case (state)
          OWNED: begin
            if (!owner_elig) begin
              grant     <= '0;
              bus_valid <= 1'b0;
              bus_data  <= '0;
              bus_str   <= 3'd0;
              rr_ptr    <= add_mod(owner, 1);
              state     <= IDLE;
            end else if (stronger) begin
              grant     <= '0;
              bus_valid <= 1'b0;
              bus_data  <= '0;
              bus_str   <= 3'd0;
              preempt   <= 1'b1;
              cand      <= win_idx;
              rr_ptr    <= add_mod(owner, 1);
              state     <= HANDOVER;
            end else begin
              bus_data <= data_of[owner];
              bus_str  <= owner_str;
            end
          end
          HANDOVER: begin
            // Nobody is left to take the bus, so it stays dead.
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_strength_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_strength_bus_arbiter
//
// Directed testbench for strength_bus_arbiter with N_REQ=4 and DW=8.
// A table of single-cycle vectors holds the inputs for each cycle and the
// outputs expected after that clock edge. Hand-written sequences follow for
// the round-robin rotation and for the fallback after a failed handover.
// -----------------------------------------------------------------------------
module tb_strength_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_str;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [7:0]  bus_data;
  logic [2:0]  bus_str;
  logic        bus_valid;
  logic        preempt;
  logic        conflict;

  int tests_run;
  int tests_failed;

  strength_bus_arbiter #(.N_REQ(4), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_str  (req_str),
    .req_data (req_data),
    .grant    (grant),
    .bus_data (bus_data),
    .bus_str  (bus_str),
    .bus_valid(bus_valid),
    .preempt  (preempt),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  // A vector holds the inputs for one cycle and the outputs expected after
  // that clock edge. When chk_bus is 0, bus_data and bus_str are not compared
  // on that cycle.
  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] str;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [7:0]  bdata;
    logic [2:0]  bstr;
    logic        chk_bus;
    logic        preempt;
    logic        conflict;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string name, input logic r, input logic [3:0] rq,
                        input logic [11:0] s, input logic [31:0] d,
                        input logic [3:0] g, input logic [7:0] bd, input logic [2:0] bs,
                        input logic cb, input logic p, input logic c);
    vec_t v;
    v.name = name; v.rst = r; v.req = rq; v.str = s; v.data = d;
    v.grant = g; v.bdata = bd; v.bstr = bs; v.chk_bus = cb;
    v.preempt = p; v.conflict = c;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, what, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq,
                               input logic [11:0] s, input logic [31:0] d);
    rst      = r;
    req      = rq;
    req_str  = s;
    req_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g,
                             input logic [7:0] bd, input logic [2:0] bs,
                             input logic cb, input logic p, input logic c);
    compare(name, "grant",     32'(grant),     32'(g));
    compare(name, "bus_valid", 32'(bus_valid), 32'(|g));
    compare(name, "preempt",   32'(preempt),   32'(p));
    compare(name, "conflict",  32'(conflict),  32'(c));
    if (cb) begin
      compare(name, "bus_data", 32'(bus_data), 32'(bd));
      compare(name, "bus_str",  32'(bus_str),  32'(bs));
    end
  endtask

  initial begin
    int          k;
    logic [3:0]  oh;
    logic [11:0] s6;
    logic [31:0] d66;

    clk          = 1'b0;
    rst          = 1'b1;
    req          = '0;
    req_str      = '0;
    req_data     = '0;
    tests_run    = 0;
    tests_failed = 0;

    // Reset with all four requesting strong; after release, tie goes to 0
    addVec("rst_hold0", 1, 4'hF, {3'd6,3'd6,3'd6,3'd6}, 32'h44332211, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    addVec("rst_hold1", 1, 4'hF, {3'd6,3'd6,3'd6,3'd6}, 32'h44332211, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    addVec("rst_grant", 0, 4'hF, {3'd6,3'd6,3'd6,3'd6}, 32'h44332211, 4'h1, 8'h00, 3'd0, 0, 0, 1);
    addVec("rst_own",   0, 4'hF, {3'd6,3'd6,3'd6,3'd6}, 32'h44332211, 4'h1, 8'h11, 3'd6, 1, 0, 0);
    addVec("rst_mid",   1, 4'h0, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    // Strength priority: supply beats weak
    addVec("prio_grant", 0, 4'b0101, {3'd0,3'd7,3'd0,3'd3}, 32'h005500AA, 4'b0100, 8'h00, 3'd0, 0, 0, 0);
    addVec("prio_bus",   0, 4'b0101, {3'd0,3'd7,3'd0,3'd3}, 32'h005500AA, 4'b0100, 8'h55, 3'd7, 1, 0, 0);
    addVec("prio_rel",   0, 4'b0000, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    addVec("prio_rst",   1, 4'b0000, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    // Preemption: req1 pull, req3 strong arrives
    addVec("pre_grant", 0, 4'b0010, {3'd0,3'd0,3'd5,3'd0}, 32'h00005A00, 4'b0010, 8'h00, 3'd0, 0, 0, 0);
    addVec("pre_own",   0, 4'b0010, {3'd0,3'd0,3'd5,3'd0}, 32'h00005A00, 4'b0010, 8'h5A, 3'd5, 1, 0, 0);
    addVec("pre_pulse", 0, 4'b1010, {3'd6,3'd0,3'd5,3'd0}, 32'hC3005A00, 4'b0000, 8'h00, 3'd0, 1, 1, 0);
    addVec("pre_hand",  0, 4'b1010, {3'd6,3'd0,3'd5,3'd0}, 32'hC3005A00, 4'b1000, 8'h00, 3'd0, 0, 0, 0);
    addVec("pre_new",   0, 4'b1010, {3'd6,3'd0,3'd5,3'd0}, 32'hC3005A00, 4'b1000, 8'hC3, 3'd6, 1, 0, 0);
    addVec("pre_rel",   0, 4'b0000, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    // Equal strength never preempts
    addVec("eq_grant", 0, 4'b0010, {3'd0,3'd0,3'd5,3'd0}, 32'h00005A00, 4'b0010, 8'h00, 3'd0, 0, 0, 0);
    addVec("eq_hold0", 0, 4'b1010, {3'd5,3'd0,3'd5,3'd0}, 32'hC3005A00, 4'b0010, 8'h5A, 3'd5, 1, 0, 0);
    addVec("eq_hold1", 0, 4'b1010, {3'd5,3'd0,3'd5,3'd0}, 32'hC3005A00, 4'b0010, 8'h5A, 3'd5, 1, 0, 0);
    addVec("eq_rel",   0, 4'b0000, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    addVec("eq_rst",   1, 4'b0000, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    // Release beats preempt; owner then lowers its strength while holding
    addVec("rbp_grant", 0, 4'b0001, {3'd0,3'd0,3'd0,3'd6}, 32'h00000010, 4'b0001, 8'h00, 3'd0, 0, 0, 0);
    addVec("rbp_own",   0, 4'b0001, {3'd0,3'd0,3'd0,3'd6}, 32'h00000010, 4'b0001, 8'h10, 3'd6, 1, 0, 0);
    addVec("rbp_rel",   0, 4'b0010, {3'd0,3'd0,3'd7,3'd0}, 32'h00002000, 4'b0000, 8'h00, 3'd0, 1, 0, 0);
    addVec("rbp_grant1",0, 4'b0010, {3'd0,3'd0,3'd7,3'd0}, 32'h00002000, 4'b0010, 8'h00, 3'd0, 0, 0, 0);
    addVec("rbp_own1",  0, 4'b0010, {3'd0,3'd0,3'd7,3'd0}, 32'h00002000, 4'b0010, 8'h20, 3'd7, 1, 0, 0);
    addVec("lower_str", 0, 4'b0010, {3'd0,3'd0,3'd2,3'd0}, 32'h00002100, 4'b0010, 8'h21, 3'd2, 1, 0, 0);
    addVec("lower_rel", 0, 4'b0000, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    addVec("lower_rst", 1, 4'b0000, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    // Highz requester never granted nor part of a conflict
    addVec("hz_only",  0, 4'b1000, 12'h000, 32'h77000000, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    addVec("hz_mix",   0, 4'b1001, {3'd0,3'd0,3'd0,3'd3}, 32'h77000001, 4'b0001, 8'h00, 3'd0, 0, 0, 0);
    addVec("hz_own",   0, 4'b1001, {3'd0,3'd0,3'd0,3'd3}, 32'h77000001, 4'b0001, 8'h01, 3'd3, 1, 0, 0);
    addVec("hz_rel",   0, 4'b0000, 12'h000, 32'h0, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    // Reset restarts rr_ptr at 0 (rr_ptr was 1 here); reset while owned drops silently
    addVec("rr0_rst",   1, 4'hF, {3'd6,3'd6,3'd6,3'd6}, 32'h99999999, 4'h0, 8'h00, 3'd0, 1, 0, 0);
    addVec("rr0_grant", 0, 4'hF, {3'd6,3'd6,3'd6,3'd6}, 32'h99999999, 4'b0001, 8'h00, 3'd0, 0, 0, 0);
    addVec("own_rst",   1, 4'hF, {3'd7,3'd6,3'd6,3'd6}, 32'h99999999, 4'h0, 8'h00, 3'd0, 1, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].str, vecs[i].data);
      checkOutput(vecs[i].name, vecs[i].grant, vecs[i].bdata, vecs[i].bstr,
                  vecs[i].chk_bus, vecs[i].preempt, vecs[i].conflict);
    end

    // Round-robin: all four strong with equal data; each owner holds two
    // cycles, then drops for one. The expected order is 0,1,2,3,0.
    s6  = {3'd6,3'd6,3'd6,3'd6};
    d66 = 32'h66666666;
    for (int r = 0; r < 5; r++) begin
      k  = r % 4;
      oh = 4'b0001 << k;
      applyStimulus(0, 4'hF, s6, d66);
      checkOutput("rr_grant", oh, 8'h00, 3'd0, 0, 0, 0);
      applyStimulus(0, 4'hF, s6, d66);
      checkOutput("rr_hold", oh, 8'h66, 3'd6, 1, 0, 0);
      applyStimulus(0, 4'hF & ~oh, s6, d66);
      checkOutput("rr_release", 4'h0, 8'h00, 3'd0, 1, 0, 0);
    end

    // Handover where the candidate vanishes: fall back to IDLE arbitration
    // from rr_ptr=2. The tie between req0 and req2 with different data
    // raises conflict.
    applyStimulus(0, 4'b0010, {3'd0,3'd0,3'd5,3'd0}, 32'h00005A00);
    checkOutput("ho_grant", 4'b0010, 8'h00, 3'd0, 0, 0, 0);
    applyStimulus(0, 4'b1010, {3'd6,3'd0,3'd5,3'd0}, 32'hC3005A00);
    checkOutput("ho_pulse", 4'b0000, 8'h00, 3'd0, 1, 1, 0);
    applyStimulus(0, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 32'h00B200B0);
    checkOutput("ho_fallback", 4'b0100, 8'h00, 3'd0, 0, 0, 1);
    applyStimulus(0, 4'b0101, {3'd0,3'd4,3'd0,3'd4}, 32'h00B200B0);
    checkOutput("ho_own", 4'b0100, 8'hB2, 3'd4, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
